flght_seq: RTL and testbench
============================

# flght_seq

Flight sequencer ahead of `flght_cntrl`. It owns the arm/calibrate/run/land lifecycle and drives `flght_cntrl`'s `inertial_cal` and `thrst` inputs. It also slew-limits commanded thrust and lands the craft by ramping thrust to zero when commands stop arriving. Commands come from `cmd_cfg`; calibration completion comes from the inertial interface.

## Interface
- `CAL_TIMEOUT`, default 24'd10_000_000: max cycles in CAL waiting for `cal_done`.
- `WDOG_LEN`, default 26'd50_000_000: cycles without `cmd_rdy` in RUN before landing.
- `RAMP_DIV`, default 16'd50_000: cycles per slew tick.
- `STEP`, default 9'd4: max thrust change per tick.

- `clk`  in  1  system clock.
- `rst_n`  in  1  one clock; reset is synchronous and active-low.
- `strt_cal`  in  1  one-cycle pulse: begin calibration/arming.
- `cal_done`  in  1  level or pulse from inertial interface: calibration complete.
- `motors_off`  in  1  one-cycle pulse: immediate stop.
- `cmd_rdy`  in  1  one-cycle pulse: any valid command received (watchdog kick).
- `thrst_cmd`  in  9  unsigned desired thrust from `cmd_cfg`.
- `inertial_cal`  out  1  to `flght_cntrl`; high only in CAL.
- `thrst`  out  9  slewed thrust to `flght_cntrl`.
- `motors_en`  out  1  high in CAL, RUN and LAND.
- `armed`  out  1  high in RUN.
- `cal_fail`  out  1  sticky; set on calibration timeout.

## Operation
- States: IDLE, CAL, RUN, LAND. All outputs are registered.
- Reset values: state = IDLE, `thrst` = 0, `inertial_cal` = 0, `motors_en` = 0, `armed` = 0, `cal_fail` = 0. All counters are 0.
- Priority in every non-IDLE state: `motors_off` > `cal_done`/timeout > `cmd_rdy` > slew.
- IDLE:
  - `thrst` = 0.
  - `strt_cal` → CAL, clear `cal_fail`, clear cal counter.
  - `cmd_rdy`, `cal_done` and `motors_off` are ignored.
- CAL:
  - `thrst` = 0; cal counter increments each cycle.
  - `cal_done` → RUN; clear watchdog and prescaler.
  - Counter reaching CAL_TIMEOUT−1 without `cal_done` → IDLE and set `cal_fail`.
  - `strt_cal` in CAL restarts the counter.
- RUN:
  - Watchdog increments each cycle and clears on `cmd_rdy`.
  - Watchdog reaching WDOG_LEN−1 → LAND.
  - `strt_cal` is ignored.
- LAND:
  - `cmd_rdy` → RUN with watchdog cleared; `thrst` keeps its current value.
  - `thrst` reaching 0 on a tick → IDLE.
- `motors_off` in CAL, RUN or LAND → IDLE, `thrst` = 0 on the next cycle.
- Prescaler: runs only in RUN/LAND and clears on entry to either. `tick` asserts when the prescaler equals RAMP_DIV−1, then the prescaler wraps to 0.
- Slew on tick in RUN (10-bit unsigned intermediate):
  - If `thrst` < `thrst_cmd`: `thrst` ← min(`thrst`+STEP, `thrst_cmd`).
  - If `thrst` > `thrst_cmd`: `thrst` ← max(`thrst`−STEP, `thrst_cmd`).
  - Equal: hold.
- Slew on tick in LAND: `thrst` ← max(`thrst`−STEP, 0), done without wrap. `thrst_cmd` is ignored.
- `thrst_cmd` may change at any cycle; only its value at the tick cycle matters.

## Timing
- Input sampled at edge N; state and outputs change at edge N+1 (one-cycle latency).
- Calibration: `cal_done` sampled at N → `armed`=1, `inertial_cal`=0 after edge N+1.
- First RUN slew tick occurs RAMP_DIV cycles after RUN entry.
- Ramping `thrst` from 0 to a value V takes ceil(V/STEP)·RAMP_DIV cycles after RUN entry.
- Watchdog: with no `cmd_rdy`, LAND entry occurs WDOG_LEN cycles after RUN entry or after the last `cmd_rdy`.
- `motors_off` and `cmd_rdy` in the same cycle: `motors_off` wins.
- Timeout and `cal_done` in the same cycle: `cal_done` wins (→ RUN, `cal_fail` not set).
- `rst_n` low at any edge, mid-ramp or mid-cal: all state and outputs take reset values on that edge.

## Test plan
Bench parameters: CAL_TIMEOUT=100, WDOG_LEN=200, RAMP_DIV=4, STEP=8.

- Reset then `strt_cal` → `inertial_cal`=1 and `motors_en`=1 next cycle; `cal_done` at cycle 30 → `armed`=1, `inertial_cal`=0 one cycle later.
- `strt_cal`, no `cal_done` → after 100 cycles state=IDLE, `cal_fail`=1, `motors_en`=0. A new `strt_cal` clears `cal_fail`.
- In RUN with `thrst_cmd`=20 → `thrst` goes 8, 16, 20 at ticks 4/8/12 cycles after RUN entry. Then `thrst_cmd`=5 → 12, 5.
- RUN with `thrst`=20, `cmd_rdy` stopped → LAND at 200 cycles; `thrst` goes 12, 4, 0 on ticks, then IDLE.
- LAND with `thrst`=12, `cmd_rdy` pulse → RUN, `armed`=1, `thrst`=12 held. `motors_off` together with `cmd_rdy` → IDLE, `thrst`=0.
- `rst_n` low mid-ramp with `thrst`=16 → all outputs 0 on the next edge; state IDLE.

Source files
------------

// File: rtl/flght_seq.sv
// Flight sequencer: owns the IDLE/CAL/RUN/LAND lifecycle, slews commanded thrust
// and lands the craft by ramping thrust to zero when commands stop arriving.
module flght_seq #(
   parameter logic [23:0] CAL_TIMEOUT = 24'd10_000_000,
   parameter logic [25:0] WDOG_LEN    = 26'd50_000_000,
   parameter logic [15:0] RAMP_DIV    = 16'd50_000,
   parameter logic [8:0]  STEP        = 9'd4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       strt_cal,
   input  logic       cal_done,
   input  logic       motors_off,
   input  logic       cmd_rdy,
   input  logic [8:0] thrst_cmd,
   output logic       inertial_cal,
   output logic [8:0] thrst,
   output logic       motors_en,
   output logic       armed,
   output logic       cal_fail
);

   typedef enum logic [1:0] {IDLE, CAL, RUN, LAND} state_t;

   state_t      state_q, state_d;
   logic [23:0] cal_cnt_q, cal_cnt_d;
   logic [25:0] wdog_q, wdog_d;
   logic [15:0] presc_q, presc_d;
   logic [8:0]  thrst_q, thrst_d;
   logic        cal_fail_q, cal_fail_d;
   logic        inertial_cal_q, motors_en_q, armed_q;
   logic        tick;

   // Step toward the target by at most STEP; 10-bit sums keep 511+STEP from wrapping.
   function automatic logic [8:0] slew_run(input logic [8:0] cur, input logic [8:0] tgt);
      logic [9:0] up;
      logic [9:0] floor_lim;
      up        = {1'b0, cur} + {1'b0, STEP};
      floor_lim = {1'b0, tgt} + {1'b0, STEP};
      if (cur < tgt)
         slew_run = (up > {1'b0, tgt}) ? tgt : up[8:0];
      else if (cur > tgt)
         slew_run = ({1'b0, cur} < floor_lim) ? tgt : cur - STEP;
      else
         slew_run = cur;
   endfunction

   function automatic logic [8:0] slew_land(input logic [8:0] cur);
      slew_land = (cur > STEP) ? cur - STEP : 9'd0;
   endfunction

   assign tick = ((state_q == RUN) || (state_q == LAND)) && (presc_q == RAMP_DIV - 16'd1);

   always_comb begin
      state_d    = state_q;
      cal_cnt_d  = cal_cnt_q;
      wdog_d     = wdog_q;
      presc_d    = presc_q;
      thrst_d    = thrst_q;
      cal_fail_d = cal_fail_q;

      if ((state_q == RUN) || (state_q == LAND))
         presc_d = tick ? 16'd0 : presc_q + 16'd1;

      case (state_q)
         IDLE: begin
            thrst_d = 9'd0;
            if (strt_cal) begin
               state_d    = CAL;
               cal_fail_d = 1'b0;
               cal_cnt_d  = 24'd0;
            end
         end
         CAL: begin
            thrst_d = 9'd0;
            if (motors_off) begin
               state_d = IDLE;
            end else if (cal_done) begin
               state_d = RUN;
               wdog_d  = 26'd0;
               presc_d = 16'd0;
            end else if (cal_cnt_q == CAL_TIMEOUT - 24'd1) begin
               state_d    = IDLE;
               cal_fail_d = 1'b1;
            end else begin
               cal_cnt_d = strt_cal ? 24'd0 : cal_cnt_q + 24'd1;
            end
         end
         RUN: begin
            if (motors_off) begin
               state_d = IDLE;
               thrst_d = 9'd0;
            end else if (wdog_q == WDOG_LEN - 26'd1) begin
               state_d = LAND;
               presc_d = 16'd0;
            end else begin
               wdog_d = cmd_rdy ? 26'd0 : wdog_q + 26'd1;
               if (tick)
                  thrst_d = slew_run(thrst_q, thrst_cmd);
            end
         end
         LAND: begin
            if (motors_off) begin
               state_d = IDLE;
               thrst_d = 9'd0;
            end else if (cmd_rdy) begin
               state_d = RUN;
               wdog_d  = 26'd0;
               presc_d = 16'd0;
            end else if (tick) begin
               thrst_d = slew_land(thrst_q);
               if (thrst_d == 9'd0)
                  state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         cal_cnt_q      <= 24'd0;
         wdog_q         <= 26'd0;
         presc_q        <= 16'd0;
         thrst_q        <= 9'd0;
         cal_fail_q     <= 1'b0;
         inertial_cal_q <= 1'b0;
         motors_en_q    <= 1'b0;
         armed_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         cal_cnt_q      <= cal_cnt_d;
         wdog_q         <= wdog_d;
         presc_q        <= presc_d;
         thrst_q        <= thrst_d;
         cal_fail_q     <= cal_fail_d;
         inertial_cal_q <= (state_d == CAL);
         motors_en_q    <= (state_d != IDLE);
         armed_q        <= (state_d == RUN);
      end
   end

   assign inertial_cal = inertial_cal_q;
   assign thrst        = thrst_q;
   assign motors_en    = motors_en_q;
   assign armed        = armed_q;
   assign cal_fail     = cal_fail_q;

endmodule

// File: tb/tb_flght_seq.sv
// Self-checking bench for flght_seq: directed lifecycle scenarios plus a
// randomized run compared against an elapsed-time reference model.
module tb_flght_seq;

   localparam int TO = 100;
   localparam int WD = 200;
   localparam int RD = 4;
   localparam int ST = 8;

   localparam int M_IDLE = 0;
   localparam int M_CAL  = 1;
   localparam int M_RUN  = 2;
   localparam int M_LAND = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       strt_cal = 1'b0;
   logic       cal_done = 1'b0;
   logic       motors_off = 1'b0;
   logic       cmd_rdy = 1'b0;
   logic [8:0] thrst_cmd = 9'd0;
   logic       inertial_cal;
   logic [8:0] thrst;
   logic       motors_en;
   logic       armed;
   logic       cal_fail;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: mode plus ages measured in clock edges
   int m_st = M_IDLE;
   int m_thr = 0;
   int m_fail = 0;
   int m_cal = 0;
   int m_quiet = 0;
   int m_phase = 0;

   flght_seq #(
      .CAL_TIMEOUT(24'd100),
      .WDOG_LEN   (26'd200),
      .RAMP_DIV   (16'd4),
      .STEP       (9'd8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .strt_cal    (strt_cal),
      .cal_done    (cal_done),
      .motors_off  (motors_off),
      .cmd_rdy     (cmd_rdy),
      .thrst_cmd   (thrst_cmd),
      .inertial_cal(inertial_cal),
      .thrst       (thrst),
      .motors_en   (motors_en),
      .armed       (armed),
      .cal_fail    (cal_fail)
   );

   always #5 clk = ~clk;

   task automatic model_edge(input logic s, input logic cd, input logic mo,
                             input logic cr, input int cmd, input logic rn);
      bit tk;
      tk = ((m_phase + 1) % RD) == 0;
      if (!rn) begin
         m_st = M_IDLE; m_thr = 0; m_fail = 0; m_cal = 0; m_quiet = 0; m_phase = 0;
      end else begin
         case (m_st)
            M_IDLE: if (s) begin m_st = M_CAL; m_cal = 0; m_fail = 0; end
            M_CAL: begin
               if (mo) m_st = M_IDLE;
               else if (cd) begin m_st = M_RUN; m_quiet = 0; m_phase = 0; end
               else if (m_cal + 1 == TO) begin m_st = M_IDLE; m_fail = 1; end
               else m_cal = s ? 0 : m_cal + 1;
            end
            M_RUN: begin
               if (mo) begin m_st = M_IDLE; m_thr = 0; end
               else if (m_quiet + 1 == WD) begin m_st = M_LAND; m_phase = 0; end
               else begin
                  m_quiet = cr ? 0 : m_quiet + 1;
                  if (tk) begin
                     if (m_thr < cmd) m_thr = (m_thr + ST < cmd) ? m_thr + ST : cmd;
                     else if (m_thr > cmd) m_thr = (m_thr - ST > cmd) ? m_thr - ST : cmd;
                  end
                  m_phase++;
               end
            end
            default: begin
               if (mo) begin m_st = M_IDLE; m_thr = 0; end
               else if (cr) begin m_st = M_RUN; m_quiet = 0; m_phase = 0; end
               else begin
                  if (tk) begin
                     m_thr = (m_thr > ST) ? m_thr - ST : 0;
                     if (m_thr == 0) m_st = M_IDLE;
                  end
                  m_phase++;
               end
            end
         endcase
      end
   endtask

   task automatic step(input logic s, input logic cd, input logic mo, input logic cr);
      strt_cal = s; cal_done = cd; motors_off = mo; cmd_rdy = cr;
      @(posedge clk);
      model_edge(s, cd, mo, cr, int'(thrst_cmd), rst_n);
      #1;
      strt_cal = 1'b0; cal_done = 1'b0; motors_off = 1'b0; cmd_rdy = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      thrst_cmd = 9'd0;
      idle(2);
      rst_n = 1'b1;
      n_tests++; if (thrst !== 9'd0) begin n_fail++; $display("FAIL reset_thrst: got %0d expected 0", thrst); end
      n_tests++; if (inertial_cal !== 1'b0) begin n_fail++; $display("FAIL reset_ical: got %b expected 0", inertial_cal); end
      n_tests++; if (motors_en !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b expected 0", motors_en); end
      n_tests++; if (armed !== 1'b0) begin n_fail++; $display("FAIL reset_armed: got %b expected 0", armed); end
      n_tests++; if (cal_fail !== 1'b0) begin n_fail++; $display("FAIL reset_calfail: got %b expected 0", cal_fail); end
      step(1'b0, 1'b1, 1'b1, 1'b1);
      n_tests++; if (motors_en !== 1'b0) begin n_fail++; $display("FAIL idle_ignores: got en=%b expected 0", motors_en); end
   endtask

   task automatic test_cal;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      n_tests++; if ({inertial_cal, motors_en, armed} !== 3'b110) begin n_fail++; $display("FAIL cal_entry: got %b expected 110", {inertial_cal, motors_en, armed}); end
      idle(29);
      n_tests++; if (inertial_cal !== 1'b1) begin n_fail++; $display("FAIL cal_hold: got %b expected 1", inertial_cal); end
      step(1'b0, 1'b1, 1'b0, 1'b0);
      n_tests++; if ({inertial_cal, motors_en, armed} !== 3'b011) begin n_fail++; $display("FAIL cal_done_run: got %b expected 011", {inertial_cal, motors_en, armed}); end
      step(1'b0, 1'b0, 1'b1, 1'b0);
      n_tests++; if ({inertial_cal, motors_en, armed} !== 3'b000) begin n_fail++; $display("FAIL run_motors_off: got %b expected 000", {inertial_cal, motors_en, armed}); end
   endtask

   task automatic test_cal_timeout;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      idle(99);
      n_tests++; if (inertial_cal !== 1'b1) begin n_fail++; $display("FAIL timeout_early: got ical=%b expected 1", inertial_cal); end
      idle(1);
      n_tests++; if ({inertial_cal, motors_en, cal_fail} !== 3'b001) begin n_fail++; $display("FAIL timeout: got %b expected 001", {inertial_cal, motors_en, cal_fail}); end
      idle(3);
      n_tests++; if (cal_fail !== 1'b1) begin n_fail++; $display("FAIL calfail_sticky: got %b expected 1", cal_fail); end
      step(1'b1, 1'b0, 1'b0, 1'b0);
      n_tests++; if ({inertial_cal, cal_fail} !== 2'b10) begin n_fail++; $display("FAIL calfail_clear: got %b expected 10", {inertial_cal, cal_fail}); end
      step(1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_ramp;
      int exp;
      thrst_cmd = 9'd20;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      for (int k = 1; k <= 20; k++) begin
         idle(1);
         if (k <= 12) exp = ((k / 4) * ST > 20) ? 20 : (k / 4) * ST;
         else if (k < 16) exp = 20;
         else if (k < 20) exp = 12;
         else exp = 5;
         n_tests++; if (thrst !== 9'(exp)) begin n_fail++; $display("FAIL ramp_k%0d: got %0d expected %0d", k, thrst, exp); end
         if (k == 12) thrst_cmd = 9'd5;
      end
      step(1'b0, 1'b0, 1'b1, 1'b0);
      n_tests++; if ({thrst, motors_en} !== 10'd0) begin n_fail++; $display("FAIL ramp_off: got thrst=%0d en=%b expected 0/0", thrst, motors_en); end
   endtask

   task automatic test_watchdog_land;
      int exp;
      thrst_cmd = 9'd20;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      idle(199);
      n_tests++; if ({armed, thrst} !== {1'b1, 9'd20}) begin n_fail++; $display("FAIL wdog_early: got armed=%b thrst=%0d expected 1/20", armed, thrst); end
      idle(1);
      n_tests++; if ({motors_en, armed} !== 2'b10) begin n_fail++; $display("FAIL wdog_land: got %b expected 10", {motors_en, armed}); end
      for (int k = 1; k <= 12; k++) begin
         idle(1);
         exp = (k < 4) ? 20 : (k < 8) ? 12 : (k < 12) ? 4 : 0;
         n_tests++; if ({motors_en, thrst} !== {(k < 12), 9'(exp)}) begin n_fail++; $display("FAIL land_k%0d: got en=%b thrst=%0d expected %b/%0d", k, motors_en, thrst, (k < 12), exp); end
      end
   endtask

   task automatic test_land_resume;
      thrst_cmd = 9'd20;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      idle(204);
      n_tests++; if ({armed, thrst} !== {1'b0, 9'd12}) begin n_fail++; $display("FAIL land_pre: got armed=%b thrst=%0d expected 0/12", armed, thrst); end
      thrst_cmd = 9'd12;
      step(1'b0, 1'b0, 1'b0, 1'b1);
      n_tests++; if ({armed, thrst} !== {1'b1, 9'd12}) begin n_fail++; $display("FAIL land_resume: got armed=%b thrst=%0d expected 1/12", armed, thrst); end
      idle(199);
      n_tests++; if ({armed, thrst} !== {1'b1, 9'd12}) begin n_fail++; $display("FAIL resume_hold: got armed=%b thrst=%0d expected 1/12", armed, thrst); end
      idle(1);
      n_tests++; if ({motors_en, armed} !== 2'b10) begin n_fail++; $display("FAIL reland: got %b expected 10", {motors_en, armed}); end
      step(1'b0, 1'b0, 1'b1, 1'b1);
      n_tests++; if ({motors_en, armed, thrst} !== 11'd0) begin n_fail++; $display("FAIL off_beats_rdy: got en=%b armed=%b thrst=%0d expected 0/0/0", motors_en, armed, thrst); end
   endtask

   task automatic test_reset_mid_ramp;
      thrst_cmd = 9'd20;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      idle(8);
      n_tests++; if (thrst !== 9'd16) begin n_fail++; $display("FAIL midramp_pre: got %0d expected 16", thrst); end
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      n_tests++; if ({thrst, inertial_cal, motors_en, armed, cal_fail} !== 13'd0) begin n_fail++; $display("FAIL midramp_reset: got thrst=%0d flags=%b expected all 0", thrst, {inertial_cal, motors_en, armed, cal_fail}); end
      step(1'b0, 1'b1, 1'b0, 1'b1);
      n_tests++; if (motors_en !== 1'b0) begin n_fail++; $display("FAIL midramp_idle: got en=%b expected 0", motors_en); end
   endtask

   task automatic test_random;
      logic s, cd, mo, cr;
      logic [3:0] exp_flags;
      for (int i = 0; i < 5000; i++) begin
         if ($urandom_range(9) == 0) thrst_cmd = 9'($urandom_range(511));
         rst_n = ($urandom_range(1499) != 0);
         s  = ($urandom_range(19) == 0);
         cd = ($urandom_range(79) == 0);
         mo = ($urandom_range(199) == 0);
         cr = ($urandom_range(149) == 0);
         step(s, cd, mo, cr);
         rst_n = 1'b1;
         exp_flags = {(m_st == M_CAL), (m_st != M_IDLE), (m_st == M_RUN), (m_fail != 0)};
         n_tests++; if (thrst !== 9'(m_thr)) begin n_fail++; $display("FAIL rand_thrst@%0d: got %0d expected %0d", i, thrst, m_thr); end
         n_tests++; if ({inertial_cal, motors_en, armed, cal_fail} !== exp_flags) begin n_fail++; $display("FAIL rand_flags@%0d: got %b expected %b", i, {inertial_cal, motors_en, armed, cal_fail}, exp_flags); end
      end
   endtask

   initial begin
      test_reset();
      test_cal();
      test_cal_timeout();
      test_ramp();
      test_watchdog_land();
      test_land_resume();
      test_reset_mid_ramp();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
